// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master: FSM state encoding,
// response status codes and the registered request bundle.
package wb_cmd_master_pkg;

  // FSM state encoding (plain constants so older tools can consume them)
  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_BUS        = 2'd1;
  localparam logic [1:0] S_RETRY_WAIT = 2'd2;
  localparam logic [1:0] S_RESP       = 2'd3;

  // Response status codes reported on rsp_status
  localparam logic [1:0] ST_OK              = 2'b00;
  localparam logic [1:0] ST_ERR             = 2'b01;
  localparam logic [1:0] ST_TIMEOUT         = 2'b10;
  localparam logic [1:0] ST_RETRY_EXHAUSTED = 2'b11;

  // Width of the per-transfer wait counter
  localparam int WAIT_CNT_W = 16;

  // Classic (single) Wishbone cycle type identifier
  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  // Request fields held stable on the bus for the whole transfer
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wb_req_t;

endpackage

// File: rtl/wbm_watchdog.sv
// Wait-cycle watchdog for the Wishbone command master. Counts cycles while
// enabled, restarts from zero whenever cleared, and flags the cycle in which
// the count reaches TIMEOUT-1 so the master can abort the transfer.
module wbm_watchdog
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority so every bus entry starts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  // Counter register, zeroed immediately by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry only counts while the bus phase is actually running
  assign expire_o = enable_i && !clear_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle command master. Accepts one command at a time on a
// valid/ready port, runs a single Wishbone transfer (with a wait watchdog and
// optional re-issue on RTY) and returns data plus status on a response port.
// Optional feature macro: WB_CMD_MASTER_RETRY_EN -- when defined, RTY causes a
// one-cycle back-off and a re-issue (up to RETRY_MAX times); when undefined,
// RTY terminates the command with status ERR.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT   = 256,
  parameter int RETRY_MAX = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  input  logic        cmd_we,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  // Wishbone master port
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  logic [1:0]  state_q, state_d;
  wb_req_t     req_q, req_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic        alive_q;
  logic        in_bus;
  logic        wd_expire;

  assign in_bus = (state_q == S_BUS);

`ifdef WB_CMD_MASTER_RETRY_EN
  localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               retry_left;

  assign retry_left = ({{(32 - RETRY_W){1'b0}}, retry_q} < RETRY_MAX);
`else
  // Retry limit has no meaning when RTY is handled as an error
  logic unused_retry_max;
  assign unused_retry_max = (RETRY_MAX != 0);
`endif

  // The watchdog is held at zero outside BUS, so every entry into BUS
  // (first issue or re-issue) restarts the wait count.
  wbm_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .clear_i  (!in_bus),
    .enable_i (in_bus),
    .expire_o (wd_expire)
  );

  // Transfer sequencing: accept, run bus phase, resolve termination, respond
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
`ifdef WB_CMD_MASTER_RETRY_EN
    retry_d      = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          req_d.adr = cmd_adr;
          req_d.dat = cmd_dat;
          req_d.sel = cmd_sel;
          req_d.we  = cmd_we;
`ifdef WB_CMD_MASTER_RETRY_EN
          retry_d   = '0;
`endif
          state_d   = S_BUS;
        end
      end
      S_BUS: begin
        // Terminations beat the watchdog; among them err > ack > rty
        if (wb_err_i) begin
          rsp_dat_d    = '0;
          rsp_status_d = ST_ERR;
          state_d      = S_RESP;
        end else if (wb_ack_i) begin
          rsp_dat_d    = req_q.we ? 32'h0 : wb_dat_i;
          rsp_status_d = ST_OK;
          state_d      = S_RESP;
        end else if (wb_rty_i) begin
`ifdef WB_CMD_MASTER_RETRY_EN
          if (retry_left) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_RETRY_WAIT;
          end else begin
            rsp_dat_d    = '0;
            rsp_status_d = ST_RETRY_EXHAUSTED;
            state_d      = S_RESP;
          end
`else
          rsp_dat_d    = '0;
          rsp_status_d = ST_ERR;
          state_d      = S_RESP;
`endif
        end else if (wd_expire) begin
          rsp_dat_d    = '0;
          rsp_status_d = ST_TIMEOUT;
          state_d      = S_RESP;
        end
      end
`ifdef WB_CMD_MASTER_RETRY_EN
      S_RETRY_WAIT: begin
        // One idle cycle with cyc/stb low, then re-issue the same request
        state_d = S_BUS;
      end
`endif
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request and response registers; reset abandons any transfer
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
      alive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      alive_q      <= 1'b1;
    end
  end

`ifdef WB_CMD_MASTER_RETRY_EN
  // Re-issue counter, cleared when a new command is accepted
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  // cmd_ready is held low during reset and rises on the first edge after it
  assign cmd_ready  = alive_q && (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;

  // cyc/stb decode straight from the state register so reset drops them
  // at once and they fall in the cycle after any sampled termination
  assign wb_cyc_o = in_bus;
  assign wb_stb_o = in_bus;
  assign wb_adr_o = req_q.adr;
  assign wb_dat_o = req_q.dat;
  assign wb_sel_o = req_q.sel;
  assign wb_we_o  = req_q.we;
  assign wb_cti_o = CTI_CLASSIC;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master (TIMEOUT=8, RETRY_MAX=3).
// Expected results follow WB_CMD_MASTER_RETRY_EN when it is defined.
module tb_wb_cmd_master;
  import wb_cmd_master_pkg::*;

  localparam int TO = 8;
  localparam int RM = 3;
`ifdef WB_CMD_MASTER_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  // termination codes {err, ack, rty}
  localparam logic [2:0] T_ACK = 3'b010;
  localparam logic [2:0] T_ERR = 3'b100;
  localparam logic [2:0] T_RTY = 3'b001;
  localparam logic [2:0] T_AE  = 3'b110;
  localparam logic [2:0] T_AR  = 3'b011;
  localparam logic [2:0] T_NO  = 3'b000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  wb_cmd_master #(.TIMEOUT(TO), .RETRY_MAX(RM)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_we(cmd_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_status(rsp_status),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // ---------------- responder: one planned termination per stb pulse,
  // raised one cycle after stb is first seen
  logic [2:0]  plan_t [0:7];
  int          plan_len = 0;
  int          plan_gen = 0;
  logic [31:0] resp_dat_cfg = 32'h0;
  int          r_idx = 0;
  int          r_gen = 0;
  logic        served;

  function int cur_idx();
    return (r_gen != plan_gen) ? 0 : r_idx;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wb_ack_i <= 1'b0; wb_err_i <= 1'b0; wb_rty_i <= 1'b0;
      wb_dat_i <= 32'h0; served <= 1'b0;
    end else begin
      r_gen <= plan_gen;
      r_idx <= cur_idx();
      if (!(wb_cyc_o && wb_stb_o)) begin
        wb_ack_i <= 1'b0; wb_err_i <= 1'b0; wb_rty_i <= 1'b0;
        served <= 1'b0;
      end else if (!served) begin
        served <= 1'b1;
        if (cur_idx() < plan_len) begin
          {wb_err_i, wb_ack_i, wb_rty_i} <= plan_t[cur_idx()];
          wb_dat_i <= resp_dat_cfg;
          r_idx <= cur_idx() + 1;
        end
      end else begin
        wb_ack_i <= 1'b0; wb_err_i <= 1'b0; wb_rty_i <= 1'b0;
      end
    end
  end

  // ---------------- monitors
  int          cyc_cnt = 0, acc_count = 0, acc_cyc = 0, acc_seen = 0;
  int          stb_pulses = 0, stb_high = 0, gap_sum = 0, low_run = 0;
  int          rsp_rise_cyc = 0, dbl_viol = 0;
  logic        stb_prev = 1'b0, rsp_prev = 1'b0, term_seen = 1'b0;
  logic [31:0] snap_adr = 32'h0, snap_dat = 32'h0;
  logic [3:0]  snap_sel = 4'h0;
  logic        snap_we = 1'b0;

  always @(posedge sys_clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (cmd_valid && cmd_ready) begin
      acc_count <= acc_count + 1;
      acc_cyc   <= cyc_cnt;
    end
    term_seen <= wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i);
  end

  always @(negedge sys_clk) begin
    stb_prev <= wb_stb_o;
    rsp_prev <= rsp_valid;
    acc_seen <= acc_count;
    if (wb_stb_o) begin
      stb_high <= stb_high + 1;
      low_run  <= 0;
      if (!stb_prev) begin
        stb_pulses <= stb_pulses + 1;
        if (acc_seen == acc_count) gap_sum <= gap_sum + low_run;
        snap_adr <= wb_adr_o; snap_dat <= wb_dat_o;
        snap_sel <= wb_sel_o; snap_we  <= wb_we_o;
      end
    end else begin
      low_run <= low_run + 1;
    end
    if (rsp_valid && !rsp_prev) rsp_rise_cyc <= cyc_cnt;
    if (term_seen && wb_stb_o) dbl_viol <= dbl_viol + 1;
  end

  // ---------------- scoreboard and helpers
  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_plan(input int len, input logic [2:0] p0, input logic [2:0] p1,
                          input logic [2:0] p2, input logic [2:0] p3, input logic [31:0] d);
    plan_t[0] = p0; plan_t[1] = p1; plan_t[2] = p2; plan_t[3] = p3;
    plan_len = len; resp_dat_cfg = d;
    plan_gen++;
  endtask

  task automatic send(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, input bit push, input logic [1:0] est, input logic [31:0] edat);
    int n = 0;
    exp_t e;
    if (push) begin
      e.st = est; e.dat = edat;
      sb.push_back(e);
    end
    @(negedge sys_clk);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++; errors++;
      $error("FAIL cmd_ready_wait observed=%b expected=1", cmd_ready);
    end
    cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_we = we;
    cmd_valid = 1'b1;
    $display("CMD adr=%08h dat=%08h sel=%b we=%b", adr, dat, sel, we);
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    exp_t e;
    while (!(rsp_valid === 1'b1 && rsp_ready === 1'b1) && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    if (rsp_valid !== 1'b1 || rsp_ready !== 1'b1 || sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_rsp observed=no_response expected=response within %0d cycles", tag, n);
      sb.delete();
    end else begin
      e = sb.pop_front();
      $display("RSP %s status=%b dat=%08h", tag, rsp_status, rsp_dat);
      chk({tag, "_status"}, 64'(rsp_status), 64'(e.st));
      chk({tag, "_dat"}, 64'(rsp_dat), 64'(e.dat));
    end
    @(negedge sys_clk);
  endtask

  // ---------------- directed sequence
  initial begin
    int b_p, b_h, b_g, n;
    sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    cmd_sel = 4'h0; cmd_we = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) plan_t[i] = T_NO;

    // reset state
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_cyc", 64'(wb_cyc_o), 64'(0));
    chk("rst_stb", 64'(wb_stb_o), 64'(0));
    chk("rst_we", 64'(wb_we_o), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_outs", 64'({wb_adr_o, rsp_dat}), 64'(0));
    chk("rst_misc", 64'({wb_dat_o, wb_sel_o, rsp_status, wb_cti_o}), 64'(0));
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk("rel_cmd_ready_low", 64'(cmd_ready), 64'(0));
    @(negedge sys_clk);
    chk("rel_cmd_ready_high", 64'(cmd_ready), 64'(1));

    // read with ack one cycle after stb
    set_plan(1, T_ACK, T_NO, T_NO, T_NO, 32'hDEADBEEF);
    b_p = stb_pulses;
    send(32'h0000_0100, 32'h0, 4'hF, 1'b0, 1'b1, ST_OK, 32'hDEADBEEF);
    wait_rsp("read");
    chk("read_latency", 64'(rsp_rise_cyc - acc_cyc), 64'(3));
    chk("read_pulses", 64'(stb_pulses - b_p), 64'(1));
    chk("read_adr", 64'(snap_adr), 64'(32'h0000_0100));
    chk("read_we", 64'(snap_we), 64'(0));
    chk("cti", 64'(wb_cti_o), 64'(3'b000));

    // write: data on the bus, zero data in the response
    set_plan(1, T_ACK, T_NO, T_NO, T_NO, 32'hBAD0BAD0);
    send(32'hFF00_0000, 32'h41, 4'b0001, 1'b1, 1'b1, ST_OK, 32'h0);
    wait_rsp("write");
    chk("write_bus", 64'({snap_we, snap_sel, snap_dat}), 64'({1'b1, 4'b0001, 32'h41}));
    chk("write_adr", 64'(snap_adr), 64'(32'hFF00_0000));

    // rty, rty, ack
    set_plan(3, T_RTY, T_RTY, T_ACK, T_NO, 32'hCAFE0001);
    b_p = stb_pulses; b_g = gap_sum;
    send(32'h2000_0040, 32'h0, 4'hF, 1'b0, 1'b1, RETRY_EN ? ST_OK : ST_ERR,
         RETRY_EN ? 32'hCAFE0001 : 32'h0);
    wait_rsp("rty2");
    chk("rty2_pulses", 64'(stb_pulses - b_p), RETRY_EN ? 64'(3) : 64'(1));
    chk("rty2_gaps", 64'(gap_sum - b_g), RETRY_EN ? 64'(2) : 64'(0));
    chk("rty2_adr", 64'(snap_adr), 64'(32'h2000_0040));

    // four rty in a row on a write
    set_plan(4, T_RTY, T_RTY, T_RTY, T_RTY, 32'h0);
    b_p = stb_pulses; b_g = gap_sum;
    send(32'h3000_0000, 32'h55, 4'b1100, 1'b1, 1'b1, RETRY_EN ? ST_RETRY_EXHAUSTED : ST_ERR, 32'h0);
    wait_rsp("rty4");
    chk("rty4_pulses", 64'(stb_pulses - b_p), RETRY_EN ? 64'(4) : 64'(1));
    chk("rty4_gaps", 64'(gap_sum - b_g), RETRY_EN ? 64'(3) : 64'(0));
    chk("rty4_bus", 64'({snap_we, snap_sel, snap_dat}), 64'({1'b1, 4'b1100, 32'h55}));

    // no termination: watchdog
    set_plan(0, T_NO, T_NO, T_NO, T_NO, 32'h0);
    b_p = stb_pulses; b_h = stb_high;
    send(32'h4000_0000, 32'h0, 4'hF, 1'b0, 1'b1, ST_TIMEOUT, 32'h0);
    wait_rsp("timeout");
    chk("timeout_stb_cycles", 64'(stb_high - b_h), 64'(TO));
    chk("timeout_pulses", 64'(stb_pulses - b_p), 64'(1));

    // ack with err: err wins
    set_plan(1, T_AE, T_NO, T_NO, T_NO, 32'h1111_1111);
    send(32'h5000_0000, 32'h0, 4'hF, 1'b0, 1'b1, ST_ERR, 32'h0);
    wait_rsp("ack_err");

    // ack with rty: ack wins
    set_plan(1, T_AR, T_NO, T_NO, T_NO, 32'h2222_2222);
    b_p = stb_pulses;
    send(32'h5000_0004, 32'h0, 4'hF, 1'b0, 1'b1, ST_OK, 32'h2222_2222);
    wait_rsp("ack_rty");
    chk("ack_rty_pulses", 64'(stb_pulses - b_p), 64'(1));

    // rsp_ready held low: response must hold
    rsp_ready = 1'b0;
    set_plan(1, T_ACK, T_NO, T_NO, T_NO, 32'h1234_5678);
    send(32'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b1, ST_OK, 32'h1234_5678);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("hold_rsp_dat", 64'(rsp_dat), 64'(32'h1234_5678));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
      @(negedge sys_clk);
    end
    rsp_ready = 1'b1;
    wait_rsp("hold");
    chk("hold_cmd_ready_after", 64'(cmd_ready), 64'(1));
    chk("hold_rsp_valid_after", 64'(rsp_valid), 64'(0));

    // reset in the middle of a bus phase
    set_plan(0, T_NO, T_NO, T_NO, T_NO, 32'h0);
    send(32'h6000_0000, 32'h77, 4'hF, 1'b1, 1'b0, ST_OK, 32'h0);
    n = 0;
    while (wb_stb_o !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("midrst_stb_before", 64'(wb_stb_o), 64'(1));
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
    chk("midrst_ready_valid", 64'({cmd_ready, rsp_valid}), 64'(0));
    chk("midrst_adr", 64'(wb_adr_o), 64'(0));
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("midrst_ready_after", 64'(cmd_ready), 64'(1));
    chk("midrst_no_rsp", 64'(rsp_valid), 64'(0));

    // normal read after the reset
    set_plan(1, T_ACK, T_NO, T_NO, T_NO, 32'hA5A5_A5A5);
    send(32'h0000_0104, 32'h0, 4'hF, 1'b0, 1'b1, ST_OK, 32'hA5A5_A5A5);
    wait_rsp("post_rst");
    chk("post_rst_latency", 64'(rsp_rise_cyc - acc_cyc), 64'(3));

    chk("no_stb_after_term", 64'(dbl_viol), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256: bus cycles a transfer waits for a termination before abort; legal range 2..65535.
REQ-002 SHALL have parameter RETRY_MAX, default 3: maximum re-issues after RTY.
REQ-003 SHALL have sys_clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have cmd_valid  in  1, cmd_ready  out  1: command handshake.
REQ-006 SHALL have cmd_adr  in  32, cmd_dat  in  32, cmd_sel  in  4, cmd_we  in  1: address, write data, byte lanes, write flag.
REQ-007 SHALL have rsp_valid  out  1, rsp_ready  in  1: response handshake.
REQ-008 SHALL have rsp_dat  out  32 (read data) and rsp_status  out  2 (00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED).
REQ-009 SHALL have wb_adr_o 32, wb_dat_o 32, wb_sel_o 4, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1, wb_cti_o 3 (all out); wb_dat_i 32, wb_ack_i 1, wb_err_i 1, wb_rty_i 1 (all in).

Function
REQ-010 SHALL implement states IDLE, BUS, RETRY_WAIT, RESP.
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid&cmd_ready at a rising edge.
REQ-012 On acceptance SHALL register adr/dat/sel/we to the wb_*_o outputs, enter BUS, and assert wb_cyc_o=wb_stb_o=1 from the next cycle.
REQ-013 wb_cti_o SHALL be constant 3'b000 (classic cycle); wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o SHALL be stable for the whole transfer including retries.
REQ-014 In BUS, termination SHALL be sampled at the rising edge; priority err > ack > rty when several are high together.
REQ-015 On ack: capture wb_dat_i into rsp_dat (reads; 0 for writes), status OK, drop cyc/stb next cycle, enter RESP.
REQ-016 On err: rsp_dat=0, status ERR, drop cyc/stb, enter RESP.
REQ-017 On rty: drop cyc/stb for exactly one cycle (RETRY_WAIT), then re-enter BUS with cyc/stb high, if fewer than RETRY_MAX retries done; otherwise status RETRY_EXHAUSTED, enter RESP.
REQ-018 A 16-bit wait counter SHALL clear on entry to BUS and increment per BUS cycle; at count TIMEOUT-1 with no termination, status TIMEOUT, drop cyc/stb, enter RESP; a termination in that same cycle SHALL win over timeout.
REQ-019 Retry counter SHALL clear on command acceptance; wait counter SHALL restart on each retry.
REQ-020 In RESP rsp_valid SHALL be 1 and rsp_dat/rsp_status stable until rsp_valid&rsp_ready, then IDLE; cmd_ready SHALL rise the cycle after.
REQ-021 Latency with a responder acking one cycle after stb: accept cycle 0, stb cycle 1, ack cycle 2, rsp_valid cycle 3.
REQ-022 wb_stb_o SHALL never be high in a cycle following a sampled termination (no double-ack).

Reset
REQ-023 Assertion of sys_rst_n=0 SHALL immediately force IDLE, cyc/stb/we=0, rsp_valid=0, cmd_ready=0, all data/address/sel/status outputs and counters 0.
REQ-024 cmd_ready SHALL become 1 on the first rising edge after deassertion; a transfer in flight at reset SHALL be abandoned without response.

Configuration
REQ-025 Macro WB_CMD_MASTER_RETRY_EN: defined -> REQ-017 retry behaviour; undefined -> rty treated exactly as err (status ERR), RETRY_WAIT state and retry counter absent, RETRY_MAX ignored.

Structure
REQ-026 Package wb_cmd_master_pkg SHALL hold state encoding and rsp_status codes (ST_OK, ST_ERR, ST_TIMEOUT, ST_RETRY_EXHAUSTED).
REQ-027 Wait counter SHALL be sub-module wbm_watchdog (clear, enable, expire at TIMEOUT-1).

Verification
REQ-028 Read 0x00000100, responder acks next cycle with 0xDEADBEEF -> rsp_valid cycle 3, rsp_dat=0xDEADBEEF, status 00, stb high exactly one cycle.
REQ-029 Write 0xFF000000 dat 0x41 sel 0001 -> wb_we_o=1, wb_sel_o=0001 during transfer, status 00, rsp_dat 0.
REQ-030 Responder raises rty twice then ack (RETRY_EN, RETRY_MAX=3) -> three stb pulses separated by one idle cycle, status 00; with 4 rty -> status 11; without macro first rty -> status 01.
REQ-031 No termination, TIMEOUT=8 -> cyc/stb high 8 cycles, then status 10; ack and err in same cycle -> status 01.
REQ-032 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_dat stable, cmd_ready 0 throughout.
REQ-033 sys_rst_n pulsed low mid-BUS -> cyc/stb 0 without waiting for a clock edge, no response, next command completes normally.
